// File: rtl/turn_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// turn_sequencer_if : battlefront, damage-calculator and VGA-slot signals
// Revision 1.0
// ---------------------------------------------------------------------------
interface turn_sequencer_if #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 2,
  parameter int TURN_W    = 8
);
  logic [NUM_LANES-1:0] lane_mask;
  logic [NUM_LANES-1:0] bf_done;
  logic [NUM_LANES-1:0] bf_ack;
  logic                 move_scen;
  logic                 dmg_start;
  logic [LANE_W-1:0]    dmg_lane;
  logic                 dmg_done;
  logic                 dmg_ack;
  logic                 game_scen;
  logic                 vga_write;
  logic                 busy;
  logic [TURN_W-1:0]    turn_count;
  logic                 timeout_err;

  modport master (
    input  lane_mask, bf_done, dmg_done, game_scen,
    output bf_ack, move_scen, dmg_start, dmg_lane, dmg_ack,
           vga_write, busy, turn_count, timeout_err
  );

  modport slave (
    output lane_mask, bf_done, dmg_done, game_scen,
    input  bf_ack, move_scen, dmg_start, dmg_lane, dmg_ack,
           vga_write, busy, turn_count, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/turn_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// turn_sequencer : battle-turn FSM - gather lanes, damage each lane, VGA write
// Revision 1.0
// ---------------------------------------------------------------------------
module turn_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  parameter int TIMEOUT   = 1024,
  parameter int TMO_W     = 16,
  parameter int TURN_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  turn_sequencer_if.master bus
);

  typedef enum logic [5:0] {
    S_WAIT_BF   = 6'b000001,
    S_MOVE      = 6'b000010,
    S_START_DAM = 6'b000100,
    S_WAIT_DAM  = 6'b001000,
    S_APP_DAM   = 6'b010000,
    S_WRITE_VGA = 6'b100000
  } state_e;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] active_q, active_d;
  logic [NUM_LANES-1:0] pending_q, pending_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [TMO_W-1:0]     cnt_q, cnt_d;
  logic [TURN_W-1:0]    turn_q, turn_d;
  logic                 tmo_q, tmo_d;

  logic                 all_done;
  logic [NUM_LANES-1:0] pending_left;

  function automatic logic [LANE_W-1:0] lowest_set(input logic [NUM_LANES-1:0] m);
    lowest_set = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = LANE_W'(i);
    end
  endfunction

  // Disabled lanes' done bits are masked out; an empty mask never starts a turn.
  assign all_done     = (bus.lane_mask != '0) &&
                        ((bus.bf_done & bus.lane_mask) == bus.lane_mask);
  assign pending_left = pending_q & ~(NUM_LANES'(1) << lane_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WAIT_BF;
      active_q  <= '0;
      pending_q <= '0;
      lane_q    <= '0;
      cnt_q     <= '0;
      turn_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      lane_q    <= lane_d;
      cnt_q     <= cnt_d;
      turn_q    <= turn_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    turn_d    = turn_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_WAIT_BF: begin
        if (all_done) begin
          state_d   = S_MOVE;
          active_d  = bus.lane_mask;
          pending_d = bus.lane_mask;
        end
      end
      S_MOVE: begin
        state_d = S_START_DAM;
        lane_d  = lowest_set(pending_q);
      end
      S_START_DAM: begin
        state_d = S_WAIT_DAM;
        cnt_d   = '0;
      end
      S_WAIT_DAM: begin
        cnt_d = cnt_q + TMO_W'(1);
        // A real completion on the last watchdog cycle takes priority.
        if (bus.dmg_done) begin
          state_d = S_APP_DAM;
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_APP_DAM;
          tmo_d   = 1'b1;
        end
      end
      S_APP_DAM: begin
        pending_d = pending_left;
        if (pending_left != '0) begin
          state_d = S_START_DAM;
          lane_d  = lowest_set(pending_left);
        end else begin
          state_d = S_WRITE_VGA;
        end
      end
      S_WRITE_VGA: begin
        if (bus.game_scen) begin
          state_d = S_WAIT_BF;
          turn_d  = turn_q + TURN_W'(1);
        end
      end
      default: state_d = S_WAIT_BF;
    endcase
  end

  assign bus.bf_ack      = (state_q == S_WRITE_VGA) ? active_q : '0;
  assign bus.move_scen   = (state_q == S_MOVE);
  assign bus.dmg_start   = (state_q == S_START_DAM);
  assign bus.dmg_ack     = (state_q == S_APP_DAM);
  assign bus.vga_write   = (state_q == S_WRITE_VGA);
  assign bus.busy        = (state_q != S_WAIT_BF);
  assign bus.dmg_lane    = lane_q;
  assign bus.turn_count  = turn_q;
  assign bus.timeout_err = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_turn_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_turn_sequencer : directed self-checking bench (4 lanes, TIMEOUT=8, TURN_W=2)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_turn_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  turn_sequencer_if #(.NUM_LANES(4), .LANE_W(2), .TURN_W(2)) bus ();

  turn_sequencer #(
    .NUM_LANES (4),
    .LANE_W    (2),
    .TIMEOUT   (8),
    .TMO_W     (16),
    .TURN_W    (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] lane_seq [0:7];
  int n_start, n_move, move_cyc, ack_gap;
  logic tmo_at_ack;
  int exp_turn;
  logic busy_seen, found;
  int tseq [0:4] = '{1, 2, 3, 0, 1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {18'b0, bus.bf_ack, bus.move_scen, bus.dmg_start, bus.dmg_lane,
            bus.dmg_ack, bus.vga_write, bus.busy, bus.turn_count, bus.timeout_err};
  endfunction

  // One full turn; delay < 0 means the damage calculator never answers.
  task automatic run_turn(input logic [3:0] mask, input int delay);
    int since;
    n_start  = 0;
    n_move   = 0;
    move_cyc = -1;
    ack_gap  = -1;
    since    = -1;
    bus.lane_mask = mask;
    bus.bf_done   = mask;
    for (int cyc = 0; cyc < 400 && !bus.vga_write; cyc++) begin
      tick();
      if (bus.move_scen) begin
        if (move_cyc < 0) move_cyc = cyc;
        n_move++;
      end
      if (bus.dmg_start) begin
        if (n_start < 8) lane_seq[n_start] = bus.dmg_lane;
        n_start++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (bus.dmg_ack) begin
        ack_gap      = since;
        tmo_at_ack   = bus.timeout_err;
        bus.dmg_done = 1'b0;
        since        = -1;
      end else if (delay >= 0 && since == delay) begin
        bus.dmg_done = 1'b1;
      end
    end
    check("vga_reached", bus.vga_write, 1);
    check("bf_ack_vga", bus.bf_ack, mask);
    repeat (2) tick();
    check("vga_held", {bus.vga_write, bus.busy, bus.bf_ack}, {2'b11, mask});
    bus.game_scen = 1'b1;
    tick();
    exp_turn = (exp_turn + 1) % 4;
    check("turn_count", bus.turn_count, exp_turn);
    check("vga_drop", {bus.vga_write, bus.busy, bus.bf_ack}, 0);
    bus.game_scen = 1'b0;
    bus.bf_done   = 4'b0000;
  endtask

  initial begin
    reset         = 1'b1;
    bus.lane_mask = '0;
    bus.bf_done   = '0;
    bus.dmg_done  = 1'b0;
    bus.game_scen = 1'b0;
    exp_turn      = 0;
    repeat (2) tick();
    check("reset_outs", outs(), 0);
    reset = 1'b0;

    // All four lanes, partial done first
    bus.lane_mask = 4'b1111;
    bus.bf_done   = 4'b0011;
    repeat (3) tick();
    check("partial_idle", bus.busy, 0);
    run_turn(4'b1111, 2);
    check("t1_moves", n_move, 1);
    check("t1_move_lat", move_cyc, 0);
    check("t1_starts", n_start, 4);
    for (int i = 0; i < 4; i++) check("t1_lane", lane_seq[i], i);
    check("t1_gap", ack_gap, 3);
    check("t1_tmo", bus.timeout_err, 0);

    // Sparse mask; done bits on disabled lanes must not start a turn
    bus.lane_mask = 4'b1010;
    bus.bf_done   = 4'b0101;
    repeat (3) tick();
    check("masked_idle", bus.busy, 0);
    run_turn(4'b1010, 1);
    check("t2_starts", n_start, 2);
    check("t2_lane0", lane_seq[0], 1);
    check("t2_lane1", lane_seq[1], 3);

    // Empty mask never starts
    bus.lane_mask = 4'b0000;
    bus.bf_done   = 4'b1111;
    busy_seen     = 1'b0;
    repeat (100) begin
      tick();
      busy_seen |= bus.busy;
    end
    check("empty_mask_idle", busy_seen, 0);
    bus.bf_done = 4'b0000;

    reset = 1'b1;
    tick();
    reset    = 1'b0;
    exp_turn = 0;
    check("reset2_outs", outs(), 0);

    // dmg_done on the final watchdog cycle wins
    run_turn(4'b0100, 8);
    check("bnd_lane", lane_seq[0], 2);
    check("bnd_gap", ack_gap, 9);
    check("bnd_tmo", tmo_at_ack, 0);
    check("bnd_tmo_after", bus.timeout_err, 0);

    // Watchdog forced completion
    run_turn(4'b0001, -1);
    check("tmo_gap", ack_gap, 9);
    check("tmo_at_ack", tmo_at_ack, 1);
    run_turn(4'b1111, 1);
    check("tmo_sticky", bus.timeout_err, 1);

    reset = 1'b1;
    tick();
    reset    = 1'b0;
    exp_turn = 0;
    check("tmo_cleared", bus.timeout_err, 0);

    // Turn counter wrap with TURN_W=2
    for (int k = 0; k < 5; k++) begin
      run_turn(4'b1001, 0);
      check("turn_seq", bus.turn_count, tseq[k]);
    end

    // Reset in the middle of lane 2's damage wait
    bus.lane_mask = 4'b1111;
    bus.bf_done   = 4'b1111;
    bus.dmg_done  = 1'b0;
    found         = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick();
      if (bus.dmg_start && bus.dmg_lane == 2'd2) found = 1'b1;
    end
    check("reach_lane2", found, 1);
    tick();
    reset       = 1'b1;
    bus.bf_done = 4'b0000;
    tick();
    check("midrst_outs", outs(), 0);
    reset    = 1'b0;
    exp_turn = 0;
    tick();
    check("midrst_idle", bus.busy, 0);
    run_turn(4'b1111, 0);
    check("restart_starts", n_start, 4);
    for (int i = 0; i < 4; i++) check("restart_lane", lane_seq[i], i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
